acs_unit: RTL

//  Hard-decision branch-metric + add-compare-select stage of the K=3, rate-1/2, 4-state Viterbi decoder.

---
 rtl/viterbi_pkg.sv | 43 ++++
 rtl/acs_unit_cell.sv | 28 ++
 rtl/acs_unit.sv | 123 ++++++++++++
 3 files changed

// File: rtl/viterbi_pkg.sv
// Shared definitions for the K=3 rate-1/2 (7,5) Viterbi decoder.
// Trellis tables are functions so the ACS and traceback agree.
package viterbi_pkg;

  localparam int NUM_STATES = 4;
  localparam int K = 3;
  localparam logic [2:0] G0 = 3'b111;
  localparam logic [2:0] G1 = 3'b101;
  localparam int PM_W_DEF = 8;

  typedef logic [1:0] state_t;
  typedef logic [1:0] sym_t;

  // State s = {u_t, u_t-1}; predecessor k of s is {s[0], k}.
  function automatic state_t pred_state(
    input state_t s,
    input logic   k
  );
    return {s[0], k};
  endfunction

  // Code symbol {c1, c0} emitted when input u leaves old state p.
  function automatic sym_t exp_sym(
    input state_t p,
    input logic   u
  );
    logic [2:0] reg3;
    reg3 = {u, p};
    return {^(reg3 & G1), ^(reg3 & G0)};
  endfunction

  // Hamming distance with erased bits contributing nothing.
  function automatic logic [1:0] sym_dist(
    input sym_t rx,
    input sym_t cw,
    input sym_t er
  );
    logic [1:0] d;
    d = (rx ^ cw) & ~er;
    return {1'b0, d[0]} + {1'b0, d[1]};
  endfunction

endpackage

// File: rtl/acs_unit_cell.sv
// One add-compare-select butterfly half: two saturating
// candidates, smaller wins, ties go to predecessor a.
module acs_cell #(
  parameter int PM_W = 8
) (
  input  logic [PM_W-1:0] pm_a,
  input  logic [PM_W-1:0] pm_b,
  input  logic [1:0]      bm_a,
  input  logic [1:0]      bm_b,
  output logic [PM_W-1:0] pm_new,
  output logic            dec
);

  logic [PM_W:0]   sum_a;
  logic [PM_W:0]   sum_b;
  logic [PM_W-1:0] cand_a;
  logic [PM_W-1:0] cand_b;

  assign sum_a = {1'b0, pm_a} + (PM_W+1)'(bm_a);
  assign sum_b = {1'b0, pm_b} + (PM_W+1)'(bm_b);

  assign cand_a = sum_a[PM_W] ? '1 : sum_a[PM_W-1:0];
  assign cand_b = sum_b[PM_W] ? '1 : sum_b[PM_W-1:0];

  assign dec    = cand_b < cand_a;
  assign pm_new = dec ? cand_b : cand_a;

endmodule

// File: rtl/acs_unit.sv
// Branch-metric + ACS stage of the 4-state Viterbi decoder.
// One symbol in, four metrics and four decision bits out a cycle later.
module acs_unit #(
  parameter int PM_W     = viterbi_pkg::PM_W_DEF,
  parameter int INIT_PM  = 32,
  parameter int NORM_THR = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  input  logic            start_i,
  input  logic [1:0]      rx_i,
  input  logic [1:0]      erase_i,
  output logic [3:0]      dec_bits_o,
  output logic [PM_W-1:0] pm_s0_o,
  output logic [PM_W-1:0] pm_s1_o,
  output logic [PM_W-1:0] pm_s2_o,
  output logic [PM_W-1:0] pm_s3_o,
  output logic            valid_o
);

  import viterbi_pkg::*;

  localparam logic [PM_W-1:0] INIT = PM_W'(INIT_PM);
  localparam logic [PM_W-1:0] THR  = PM_W'(NORM_THR);

  logic [PM_W-1:0] pm_q   [NUM_STATES];
  logic [PM_W-1:0] old_pm [NUM_STATES];
  logic [PM_W-1:0] acs_pm [NUM_STATES];
  logic [PM_W-1:0] nxt_pm [NUM_STATES];
  logic [PM_W-1:0] pm_min;
  logic            norm;
  logic [3:0]      dec_new;
  logic [3:0]      dec_q;
  logic            vld_q;
  logic [1:0]      bm [4];

  // Only four distinct code symbols exist, so one BM per symbol.
  always_comb begin
    for (int s = 0; s < 4; s++) begin
      bm[s] = sym_dist(rx_i, 2'(s), erase_i);
    end
  end

  always_comb begin
    for (int j = 0; j < NUM_STATES; j++) begin
      if (start_i) begin
        old_pm[j] = (j == 0) ? '0 : INIT;
      end else begin
        old_pm[j] = pm_q[j];
      end
    end
  end

  for (genvar j = 0; j < NUM_STATES; j++) begin : g_acs
    localparam state_t PA = pred_state(2'(j), 1'b0);
    localparam state_t PB = pred_state(2'(j), 1'b1);
    localparam logic   U  = 1'(j >> 1);
    localparam sym_t   EA = exp_sym(PA, U);
    localparam sym_t   EB = exp_sym(PB, U);

    acs_cell #(
      .PM_W(PM_W)
    ) u_cell (
      .pm_a  (old_pm[PA]),
      .pm_b  (old_pm[PB]),
      .bm_a  (bm[EA]),
      .bm_b  (bm[EB]),
      .pm_new(acs_pm[j]),
      .dec   (dec_new[j])
    );
  end

  always_comb begin
    pm_min = acs_pm[0];
    for (int j = 1; j < NUM_STATES; j++) begin
      if (acs_pm[j] < pm_min) begin
        pm_min = acs_pm[j];
      end
    end
  end

  // Shifting all metrics by the same amount keeps every decision intact.
  assign norm = pm_min >= THR;

  always_comb begin
    for (int j = 0; j < NUM_STATES; j++) begin
      nxt_pm[j] = norm ? acs_pm[j] - THR : acs_pm[j];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pm_q[0] <= '0;
      pm_q[1] <= INIT;
      pm_q[2] <= INIT;
      pm_q[3] <= INIT;
      dec_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      vld_q <= valid_i;
      if (valid_i) begin
        for (int j = 0; j < NUM_STATES; j++) begin
          pm_q[j] <= nxt_pm[j];
        end
        dec_q <= dec_new;
      end else if (start_i) begin
        pm_q[0] <= '0;
        pm_q[1] <= INIT;
        pm_q[2] <= INIT;
        pm_q[3] <= INIT;
      end
    end
  end

  assign pm_s0_o    = pm_q[0];
  assign pm_s1_o    = pm_q[1];
  assign pm_s2_o    = pm_q[2];
  assign pm_s3_o    = pm_q[3];
  assign dec_bits_o = dec_q;
  assign valid_o    = vld_q;

endmodule
